instr_fetch: RTL and testbench

//  IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; produces IR/nextInst consumed by ID.

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_ifid.sv | 49 ++++
 rtl/instr_fetch.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared constants for the IF stage. Contains the reset PC and
//               bubble defaults, the fetch FSM state encodings and the
//               jump-target helper.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Fetch FSM encodings
    localparam logic [1:0] ST_FETCH   = 2'd0;  // request outstanding at pc
    localparam logic [1:0] ST_FULL    = 2'd1;  // skid buffer holds a fetched instr
    localparam logic [1:0] ST_DISCARD = 2'd2;  // wrong-path fetch still in flight

    // MIPS J-type target: upper nibble comes from PC+4 of the jump itself
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] jmp_field);
        return {pc_plus4[31:28], jmp_field, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ifid.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register (IR, nextInst, id_valid).
//               bubble has priority over load; neither means hold.
// Ports       : clk, rst (async, active-high), load, bubble,
//               ir_in/next_in (data to load), ir/next_inst/valid (outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] ir_in,
    input  logic [31:0] next_in,
    output logic [31:0] ir,
    output logic [31:0] next_inst,
    output logic        valid
);

    logic [31:0] r_ir;
    logic [31:0] r_next;
    logic        r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= NOP_INSTR;
            r_next  <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (bubble) begin
            r_ir    <= NOP_INSTR;
            r_next  <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (load) begin
            r_ir    <= ir_in;
            r_next  <= next_in;
            r_valid <= 1'b1;
        end
    end

    assign ir        = r_ir;
    assign next_inst = r_next;
    assign valid     = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : MIPS IF stage with IF/ID register. Holds the PC, fetches over
//               a req/ack memory handshake (one outstanding request), applies
//               ID-resolved branch/jump redirects, absorbs a hazard stall with
//               a one-entry skid buffer and squashes wrong-path fetches.
// Ports       : clk, rst (async, active-high)
//               stall, PcSrc/beqAdr, Jmp/jmpAdr         - control from ID/hazard
//               imem_req/imem_addr/imem_rdata/imem_ack - instruction memory
//               IR, nextInst, id_valid                 - IF/ID to decode
//               pc                                     - current fetch PC
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        PcSrc,
    input  logic [31:0] beqAdr,
    input  logic        Jmp,
    input  logic [25:0] jmpAdr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] IR,
    output logic [31:0] nextInst,
    output logic        id_valid,
    output logic [31:0] pc
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;    // redirect target waiting for the squashed ack
    logic [31:0] r_buf_ir;     // skid buffer
    logic [31:0] r_buf_next;
    logic        r_fetch_en;   // low for one cycle after reset so req starts late

    logic [1:0]  w_state_n;
    logic [31:0] w_pc_n;
    logic [31:0] w_pend_n;
    logic [31:0] w_buf_ir_n;
    logic [31:0] w_buf_next_n;
    logic        w_ifid_load;
    logic        w_ifid_bubble;
    logic [31:0] w_ifid_ir;
    logic [31:0] w_ifid_next;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_ack;
    logic [31:0] w_pend_eff;

    // ------------------------------------------------------------------
    // Next-PC / target selection
    // ------------------------------------------------------------------
    assign w_redirect = ~stall & (PcSrc | Jmp);
    assign w_target   = PcSrc ? beqAdr : jump_target(nextInst, jmpAdr);
    assign w_pc_plus4 = r_pc + 32'd4;
    // An ack only means something while a request is actually out
    assign w_ack      = imem_ack & imem_req;
    // A redirect during DISCARD replaces the pending target
    assign w_pend_eff = w_redirect ? w_target : r_pend_pc;

    assign imem_req  = r_fetch_en & (r_state != ST_FULL);
    assign imem_addr = r_pc;
    assign pc        = r_pc;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_pend_n      = r_pend_pc;
        w_buf_ir_n    = r_buf_ir;
        w_buf_next_n  = r_buf_next;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_ifid_ir     = imem_rdata;
        w_ifid_next   = w_pc_plus4;

        if (r_fetch_en) begin
            case (r_state)
                ST_FETCH: begin
                    if (stall) begin
                        // Decode is frozen: park the returning instr in the buffer
                        if (w_ack) begin
                            w_buf_ir_n   = imem_rdata;
                            w_buf_next_n = w_pc_plus4;
                            w_pc_n       = w_pc_plus4;
                            w_state_n    = ST_FULL;
                        end
                    end else if (w_redirect) begin
                        w_ifid_bubble = 1'b1;
                        if (w_ack) begin
                            w_pc_n = w_target;
                        end else begin
                            // Address must stay stable until the stale ack returns
                            w_pend_n  = w_target;
                            w_state_n = ST_DISCARD;
                        end
                    end else if (w_ack) begin
                        w_ifid_load = 1'b1;
                        w_pc_n      = w_pc_plus4;
                    end else begin
                        w_ifid_bubble = 1'b1;
                    end
                end

                ST_FULL: begin
                    if (!stall) begin
                        if (w_redirect) begin
                            w_pc_n        = w_target;
                            w_ifid_bubble = 1'b1;
                        end else begin
                            w_ifid_load = 1'b1;
                            w_ifid_ir   = r_buf_ir;
                            w_ifid_next = r_buf_next;
                        end
                        w_state_n = ST_FETCH;
                    end
                end

                ST_DISCARD: begin
                    w_pend_n = w_pend_eff;
                    if (!stall) begin
                        w_ifid_bubble = 1'b1;
                    end
                    if (w_ack) begin
                        w_pc_n    = w_pend_eff;
                        w_state_n = ST_FETCH;
                    end
                end

                default: begin
                    w_state_n = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_buf_ir   <= NOP_INSTR;
            r_buf_next <= 32'h0000_0000;
            r_fetch_en <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_pend_pc  <= w_pend_n;
            r_buf_ir   <= w_buf_ir_n;
            r_buf_next <= w_buf_next_n;
            r_fetch_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .load      (w_ifid_load),
        .bubble    (w_ifid_bubble),
        .ir_in     (w_ifid_ir),
        .next_in   (w_ifid_next),
        .ir        (IR),
        .next_inst (nextInst),
        .valid     (id_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. Stimulus pushes expected
//               IF/ID contents into a scoreboard queue; a monitor pops and
//               compares each newly presented valid instruction. Memory model
//               returns addr ^ key after a programmable number of wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] ni;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PcSrc;
    logic [31:0] beqAdr;
    logic        Jmp;
    logic [25:0] jmpAdr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] IR;
    logic [31:0] nextInst;
    logic        id_valid;
    logic [31:0] pc;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Memory model controls
    int          ack_delay = 0;
    int          wait_cnt;
    logic        force_ack = 1'b0;
    logic [31:0] key       = 32'h0000_0000;

    localparam logic [31:0] K = 32'h5A00_0000;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .PcSrc      (PcSrc),
        .beqAdr     (beqAdr),
        .Jmp        (Jmp),
        .jmpAdr     (jmpAdr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .IR         (IR),
        .nextInst   (nextInst),
        .id_valid   (id_valid),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instruction memory model
    // ------------------------------------------------------------------
    assign imem_ack   = force_ack | (imem_req & (wait_cnt >= ack_delay));
    assign imem_rdata = imem_addr ^ key;

    always @(posedge clk or posedge rst) begin
        if (rst)                       wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] ir, input logic [31:0] ni);
        exp_t e;
        e.ir = ir;
        e.ni = ni;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: addr stability of an unacked request and scoreboard pops
    // ------------------------------------------------------------------
    logic        stall_edge = 1'b0;
    logic        pend_hold  = 1'b0;
    logic [31:0] hold_addr  = 32'h0;

    always @(posedge clk) begin
        stall_edge = stall;
        pend_hold  = !rst && imem_req && !imem_ack;
        hold_addr  = imem_addr;
    end

    always @(negedge clk) begin
        if (!rst && pend_hold) begin
            check("addr_stable_req", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, hold_addr);
        end
        // A fresh IF/ID value appears only after an edge with stall low
        if (!rst && id_valid && !stall_edge) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got IR=%08h nextInst=%08h expected none", IR, nextInst);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ir", IR, e.ir);
                check("sb_next", nextInst, e.ni);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        PcSrc  = 1'b0;
        beqAdr = 32'h0;
        Jmp    = 1'b0;
        jmpAdr = 26'h0;
        force_ack = 1'b1;   // acks during reset must be ignored

        // ---- Test 1: reset state, zero-wait streaming --------------
        tick(3);
        check("rst_ir", IR, 32'h0);
        check("rst_next", nextInst, 32'h0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        rst = 1'b0;
        force_ack = 1'b0;
        #1;
        check("req_after_rel", {31'd0, imem_req}, 32'd0);
        push(32'h0, 32'h4);
        push(32'h4, 32'h8);
        push(32'h8, 32'hC);
        tick();                                  // E1
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_valid0", {31'd0, id_valid}, 32'd0);
        tick();                                  // E2
        check("t1_valid1", {31'd0, id_valid}, 32'd1);
        tick(2);                                 // E4, pc = 0xC

        // ---- Test 2: ack after 2 wait cycles -----------------------
        ack_delay = 2;
        key = K;
        push(32'hC ^ K, 32'h10);
        tick();                                  // E5
        check("t2_bub1", {31'd0, id_valid}, 32'd0);
        check("t2_addr1", imem_addr, 32'hC);
        tick();                                  // E6
        check("t2_bub2", {31'd0, id_valid}, 32'd0);
        check("t2_addr2", imem_addr, 32'hC);
        tick();                                  // E7, loads mem[0xC]
        check("t2_pc", pc, 32'h10);

        // ---- Test 3: stall with skid buffer at pc=0x10 -------------
        ack_delay = 0;
        stall = 1'b1;
        tick();                                  // E8, fetch of 0x10 parked
        check("t3_req", {31'd0, imem_req}, 32'd0);
        check("t3_pc", pc, 32'h14);
        tick(2);                                 // E10
        check("t3_ir_held", IR, 32'hC ^ K);
        check("t3_valid_held", {31'd0, id_valid}, 32'd1);
        push(32'h10 ^ K, 32'h14);
        push(32'h14 ^ K, 32'h18);
        stall = 1'b0;
        tick(2);                                 // E12, pc = 0x18

        // ---- Test 4: branch taken with same-cycle ack --------------
        PcSrc  = 1'b1;
        beqAdr = 32'h0000_0100;
        tick();                                  // E13
        PcSrc = 1'b0;
        check("t4_bubble", {31'd0, id_valid}, 32'd0);
        check("t4_ir_nop", IR, 32'h0);
        check("t4_addr", imem_addr, 32'h100);
        push(32'h100 ^ K, 32'h104);
        tick();                                  // E14, pc = 0x104

        // ---- Test 5: jump while ack pending ------------------------
        Jmp       = 1'b1;
        jmpAdr    = 26'h40;
        ack_delay = 3;
        tick();                                  // E15 -> DISCARD
        Jmp = 1'b0;
        check("t5_bubble", {31'd0, id_valid}, 32'd0);
        check("t5_addr_old", imem_addr, 32'h104);
        tick(2);                                 // E17
        check("t5_addr_old2", imem_addr, 32'h104);
        tick();                                  // E18, stale ack consumed
        check("t5_addr_new", imem_addr, 32'h100);
        check("t5_dropped", {31'd0, id_valid}, 32'd0);
        ack_delay = 0;
        push(32'h100 ^ K, 32'h104);
        tick();                                  // E19

        // ---- Test 6: reset during DISCARD --------------------------
        ack_delay = 5;
        PcSrc     = 1'b1;
        beqAdr    = 32'h0000_0200;
        tick();                                  // E20 -> DISCARD
        PcSrc = 1'b0;
        tick();                                  // E21
        rst = 1'b1;
        force_ack = 1'b1;
        #1;
        check("t6_ir", IR, 32'h0);
        check("t6_next", nextInst, 32'h0);
        check("t6_valid", {31'd0, id_valid}, 32'd0);
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_pc", pc, 32'h0);
        tick(2);                                 // E23
        rst = 1'b0;
        force_ack = 1'b0;
        ack_delay = 0;
        push(32'h0 ^ K, 32'h4);
        push(32'h4 ^ K, 32'h8);
        tick();                                  // E24
        check("t6_restart_req", {31'd0, imem_req}, 32'd1);
        check("t6_restart_addr", imem_addr, 32'h0);
        tick(2);                                 // E26
        ack_delay = 1000;
        tick(3);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
